// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_scan_ctrl
// Description : Time-multiplexing scan controller for a 4-digit 7-segment
//               display. Each digit gets a drive window of DRIVE_CYCLES
//               followed by a blanking gap of BLANK_CYCLES with every anode
//               off. The digit select advances at the start of the gap, so
//               the downstream selector/decoder settles while the display is
//               dark.
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous reset, active-low
//               en         - scan enable (0 = display dark, frame abandoned)
//               duty[2:0]  - brightness, only with BRIGHTNESS_EN
//               sel[1:0]   - registered digit index for the 4:1 selector
//               an[3:0]    - registered active-low anode enables
//               scan_done  - one-cycle pulse when sel wraps 3 -> 0
// Options     : BRIGHTNESS_EN - adds duty input; anode on-time within the
//               drive window is (DRIVE_CYCLES/8)*(duty+1) cycles.
//               DRIVE_CYCLES must then be a multiple of 8.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
    parameter int DRIVE_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef BRIGHTNESS_EN
    input  logic [2:0] duty,
`endif
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       scan_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_drive_last = CNT_W'(DRIVE_CYCLES - 1);
    // Only meaningful when BLANK_CYCLES > 0; the BLANK state is unreachable otherwise.
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [3:0]       c_all_off    = 4'b1111;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_an;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_an_nxt;
    logic             w_done_nxt;

`ifdef BRIGHTNESS_EN
    localparam logic [CNT_W:0] c_slice = (CNT_W+1)'(DRIVE_CYCLES / 8);

    logic [2:0]       r_duty;
    logic [2:0]       w_duty_nxt;
    logic [CNT_W:0]   w_on_limit;
`endif

    function automatic logic [3:0] onehot_low(input logic [1:0] idx);
        logic [3:0] w_one;
        w_one = 4'b0001 << idx;
        return ~w_one;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_an_nxt    = c_all_off;
        w_done_nxt  = 1'b0;
`ifdef BRIGHTNESS_EN
        w_duty_nxt  = r_duty;
        w_on_limit  = '0;
`endif

        case (r_state)
            ST_IDLE: begin
                w_sel_nxt = 2'd0;
                w_cnt_nxt = '0;
                if (en) begin
                    w_state_nxt = ST_DRIVE;
                    w_an_nxt    = onehot_low(2'd0);
`ifdef BRIGHTNESS_EN
                    w_duty_nxt  = duty;
`endif
                end
            end

            ST_DRIVE: begin
                if (r_cnt == c_drive_last) begin
                    w_sel_nxt  = r_sel + 2'd1;
                    w_cnt_nxt  = '0;
                    w_done_nxt = (r_sel == 2'd3);
                    if (BLANK_CYCLES > 0) begin
                        w_state_nxt = ST_BLANK;
                        w_an_nxt    = c_all_off;
                    end else begin
                        // No gap: the next digit's window starts immediately.
                        w_an_nxt    = onehot_low(r_sel + 2'd1);
`ifdef BRIGHTNESS_EN
                        w_duty_nxt  = duty;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_an_nxt  = onehot_low(r_sel);
                end
            end

            ST_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DRIVE;
                    w_an_nxt    = onehot_low(r_sel);
`ifdef BRIGHTNESS_EN
                    w_duty_nxt  = duty;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_sel_nxt   = 2'd0;
            end
        endcase

        // Dropping enable abandons the frame; restart is always at digit 0.
        if (!en && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_sel_nxt   = 2'd0;
            w_an_nxt    = c_all_off;
            w_done_nxt  = 1'b0;
        end

`ifdef BRIGHTNESS_EN
        // Gate the anode on the cycle it will be displayed: the registered
        // an must reflect the counter value of the following cycle.
        w_on_limit = c_slice * (CNT_W+1)'(w_duty_nxt) + c_slice;
        if ((w_state_nxt == ST_DRIVE) && ({1'b0, w_cnt_nxt} >= w_on_limit)) begin
            w_an_nxt = c_all_off;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= 2'd0;
            r_an    <= c_all_off;
            r_done  <= 1'b0;
`ifdef BRIGHTNESS_EN
            r_duty  <= 3'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_an    <= w_an_nxt;
            r_done  <= w_done_nxt;
`ifdef BRIGHTNESS_EN
            r_duty  <= w_duty_nxt;
`endif
        end
    end

    assign sel       = r_sel;
    assign an        = r_an;
    assign scan_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_scan_ctrl
// Description : Self-checking bench for digit_scan_ctrl. Two instances run
//               side by side: one with a blanking gap and one without. The
//               reference model tracks only "cycles since scan start" and
//               derives digit, phase, select and anode from frame arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_ctrl;

`ifdef BRIGHTNESS_EN
    localparam int DA = 8;
    localparam int BA = 1;
    localparam int DB = 8;
    localparam int BB = 0;
`else
    localparam int DA = 4;
    localparam int BA = 2;
    localparam int DB = 3;
    localparam int BB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
`ifdef BRIGHTNESS_EN
    logic [2:0] duty = 3'd7;
`endif

    logic [1:0] dsel  [2];
    logic [3:0] dan   [2];
    logic       ddone [2];

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model state per instance
    bit         run  [2];
    int         t    [2];
    int         dq   [2];
    logic [1:0] xsel [2];
    logic [3:0] xan  [2];
    logic       xdone[2];

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DRIVE_CYCLES(DA), .BLANK_CYCLES(BA), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef BRIGHTNESS_EN
        .duty(duty),
`endif
        .sel(dsel[0]), .an(dan[0]), .scan_done(ddone[0])
    );

    digit_scan_ctrl #(.DRIVE_CYCLES(DB), .BLANK_CYCLES(BB), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef BRIGHTNESS_EN
        .duty(duty),
`endif
        .sel(dsel[1]), .an(dan[1]), .scan_done(ddone[1])
    );

    function automatic int dcyc(input int i);
        return (i == 0) ? DA : DB;
    endfunction

    function automatic int bcyc(input int i);
        return (i == 0) ? BA : BB;
    endfunction

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int d, b, slot, per, pos, dig, ph, lim;
            logic [3:0] one;
            d = dcyc(i);
            b = bcyc(i);
            slot = d + b;
            per  = 4 * slot;
            if (!rst_n || !en) begin
                run[i] = 1'b0;
                t[i]   = 0;
            end else if (!run[i]) begin
                run[i] = 1'b1;
                t[i]   = 0;
            end else begin
                t[i] = t[i] + 1;
            end
            if (!run[i]) begin
                xsel[i]  = 2'd0;
                xan[i]   = 4'b1111;
                xdone[i] = 1'b0;
            end else begin
                pos = t[i] % per;
                dig = pos / slot;
                ph  = pos % slot;
`ifdef BRIGHTNESS_EN
                if (ph == 0) dq[i] = int'(duty);
                lim = (d / 8) * (dq[i] + 1);
`else
                lim = d;
`endif
                one = 4'b0001 << dig;
                xan[i]   = (ph < d && ph < lim) ? ~one : 4'b1111;
                xsel[i]  = (ph < d) ? 2'(dig) : 2'((dig + 1) % 4);
                xdone[i] = (t[i] > 0) && (pos == ((per - b) % per));
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            string n;
            n = (i == 0) ? "a" : "b";
            check({n, ".sel"}, {2'b00, dsel[i]}, {2'b00, xsel[i]});
            check({n, ".an"}, dan[i], xan[i]);
            check({n, ".scan_done"}, {3'b000, ddone[i]}, {3'b000, xdone[i]});
            check({n, ".one_low_max"}, {3'b000, ($countones(~dan[i]) <= 1)}, 4'b0001);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        compare();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            run[i] = 1'b0; t[i] = 0; dq[i] = 7;
        end

        // Reset held with enable high: everything stays dark.
        rst_n = 1'b0;
        en    = 1'b1;
        step();
        step();
        check("rst.an", dan[0], 4'b1111);
        check("rst.sel", {2'b00, dsel[0]}, 4'b0000);

        // Release: first driving cycle shows digit 0.
        rst_n = 1'b1;
        step();
        check("first.an", dan[0], 4'b1110);

        // Several full frames on both instances.
        for (int k = 0; k < 60; k++) step();

        // Drop enable while digit 2 is driving; restart at digit 0.
        n = 0;
        while (xan[0] != 4'b1011 && n < 100) begin step(); n++; end
        check("find_digit2", {3'b000, (n < 100)}, 4'b0001);
        en = 1'b0;
        step();
        check("drop.an", dan[0], 4'b1111);
        check("drop.sel", {2'b00, dsel[0]}, 4'b0000);
        en = 1'b1;
        step();
        check("reen.an", dan[0], 4'b1110);

        // Reset in the gap after digit 2 (sel already 3): no scan_done pulse.
        n = 0;
        while (!(xsel[0] == 2'd3 && xan[0] == 4'b1111 && run[0]) && n < 100) begin
            step(); n++;
        end
        check("find_gap3", {3'b000, (n < 100)}, 4'b0001);
        rst_n = 1'b0;
        step();
        check("rstgap.sel", {2'b00, dsel[0]}, 4'b0000);
        check("rstgap.done", {3'b000, ddone[0]}, 4'b0000);
        rst_n = 1'b1;

`ifdef BRIGHTNESS_EN
        // Low duty for a couple of frames, then full duty.
        duty = 3'd1;
        for (int k = 0; k < 80; k++) step();
        duty = 3'd7;
        for (int k = 0; k < 40; k++) step();
`endif

        // Randomized enable/reset/duty activity.
        for (int k = 0; k < 400; k++) begin
            en    = ($urandom_range(0, 29) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
`ifdef BRIGHTNESS_EN
            if ($urandom_range(0, 7) == 0) duty = 3'($urandom);
`endif
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
